crc_byte_sequencer: RTL



---
 rtl/crc_byte_sequencer.sv | 124 ++++++++++++
 1 files changed

// File: rtl/crc_byte_sequencer.sv
// Byte sequencer between the CRC_DR/CRC_CR host side and the byte-wide CRC engine.
// Define CRC_SEQ_MSB_FIRST_EN to issue bytes from the most significant active byte down.
module crc_byte_sequencer (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic [31:0] bus_wr,
    input  logic [1:0]  bus_size,
    input  logic        buffer_write_en,
    input  logic        reset_chain,
    input  logic        crc_byte_ready,
    output logic [7:0]  crc_byte,
    output logic        crc_byte_en,
    output logic        crc_init_load,
    output logic        buffer_full,
    output logic        read_wait,
    output logic        reset_pending
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_INIT} state_t;

    state_t           state_q, state_d;
    logic [1:0][31:0] data_q, data_d;
    logic [1:0][2:0]  nb_q, nb_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic             wr_ptr_q, wr_ptr_d;
    logic [1:0]       count_q, count_d;
    logic [1:0]       idx_q, idx_d;
    logic [7:0]       crc_byte_q, crc_byte_d;
    logic             crc_byte_en_q, crc_byte_en_d;
    logic             crc_init_load_q, crc_init_load_d;
    logic             reset_pending_q, reset_pending_d;

    logic             push, pop, last_byte;
    logic [2:0]       push_nb;
    logic [1:0]       sel;
    logic [31:0]      head_data;

    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        nb_d     = nb_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        idx_d    = idx_q;

        push_nb   = (bus_size == 2'b00) ? 3'd1 : (bus_size == 2'b01) ? 3'd2 : 3'd4;
        push      = buffer_write_en && (count_q != 2'd2);
        last_byte = ({1'b0, idx_q} == (nb_q[rd_ptr_q] - 3'd1));
        pop       = (state_q == S_RUN) && crc_byte_ready && last_byte;

        if (reset_chain) begin
            // Abandon everything, including a same-cycle push.
            state_d  = S_INIT;
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
            count_d  = 2'd0;
            idx_d    = 2'd0;
        end else begin
            if (push) begin
                data_d[wr_ptr_q] = bus_wr;
                nb_d[wr_ptr_q]   = push_nb;
                wr_ptr_d         = ~wr_ptr_q;
            end
            if ((state_q == S_RUN) && crc_byte_ready) begin
                if (last_byte) begin
                    idx_d    = 2'd0;
                    rd_ptr_d = ~rd_ptr_q;
                end else begin
                    idx_d = idx_q + 2'd1;
                end
            end
            count_d = count_q + {1'b0, push} - {1'b0, pop};
            state_d = (count_d != 2'd0) ? S_RUN : S_IDLE;
        end

        // Outputs are precomputed from next state so they leave flops directly.
`ifdef CRC_SEQ_MSB_FIRST_EN
        sel = nb_d[rd_ptr_d][1:0] - 2'd1 - idx_d;
`else
        sel = idx_d;
`endif
        head_data       = data_d[rd_ptr_d];
        crc_byte_en_d   = (state_d == S_RUN);
        crc_byte_d      = crc_byte_en_d ? head_data[{sel, 3'b000} +: 8] : 8'h00;
        crc_init_load_d = (state_d == S_INIT);
        reset_pending_d = (state_d == S_INIT);
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q         <= S_IDLE;
            data_q          <= '0;
            nb_q            <= '0;
            rd_ptr_q        <= 1'b0;
            wr_ptr_q        <= 1'b0;
            count_q         <= 2'd0;
            idx_q           <= 2'd0;
            crc_byte_q      <= 8'h00;
            crc_byte_en_q   <= 1'b0;
            crc_init_load_q <= 1'b0;
            reset_pending_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            data_q          <= data_d;
            nb_q            <= nb_d;
            rd_ptr_q        <= rd_ptr_d;
            wr_ptr_q        <= wr_ptr_d;
            count_q         <= count_d;
            idx_q           <= idx_d;
            crc_byte_q      <= crc_byte_d;
            crc_byte_en_q   <= crc_byte_en_d;
            crc_init_load_q <= crc_init_load_d;
            reset_pending_q <= reset_pending_d;
        end
    end

    assign crc_byte      = crc_byte_q;
    assign crc_byte_en   = crc_byte_en_q;
    assign crc_init_load = crc_init_load_q;
    assign reset_pending = reset_pending_q;
    assign buffer_full   = (count_q == 2'd2);
    assign read_wait     = (count_q != 2'd0) || (state_q != S_IDLE);

endmodule
